// File: rtl/fadd_arbiter.sv
// -----------------------------------------------------------------------------
// fadd_arbiter
//   Shares one combinational single-precision fadd between two requesters.
//   Requests are arbitrated round-robin with a valid/ready handshake. A subtract
//   request is turned into an add by flipping the sign bit of operand t. The
//   granted operands are registered (entry 0) and fed to the shared fadd. The
//   fadd result is captured into a chain of result registers (entries
//   1..LATENCY-1). The last entry drives a single tagged response channel. The
//   whole pipeline stalls as one unit under response backpressure.
//
// Parameters:
//   LATENCY        number of pipeline entries, legal range 2..4
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   reqN_valid     requester N presents an operation (N = 0, 1)
//   reqN_ready     requester N's operation is accepted this cycle
//   reqN_sub       1 = s - t, 0 = s + t
//   reqN_s/reqN_t  IEEE754 single-precision operands
//   fadd_s/fadd_t  registered operands to the shared fadd (t sign-adjusted)
//   fadd_d         fadd result
//   fadd_overflow  fadd overflow flag
//   resp_valid     result available on resp_*
//   resp_ready     consumer accepts the result
//   resp_id        index of the requester that issued the result
//   resp_d         result value
//   resp_overflow  overflow flag of the result
//   busy           at least one pipeline entry holds a valid operation
// -----------------------------------------------------------------------------
module fadd_arbiter #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_sub,
    input  logic [31:0] req0_s,
    input  logic [31:0] req0_t,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_sub,
    input  logic [31:0] req1_s,
    input  logic [31:0] req1_t,
    output logic [31:0] fadd_s,
    output logic [31:0] fadd_t,
    input  logic [31:0] fadd_d,
    input  logic        fadd_overflow,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_d,
    output logic        resp_overflow,
    output logic        busy
);

    localparam int LAST = LATENCY - 1;

    // Entry 0: registered operands feeding the shared fadd
    logic        r_v0;
    logic        r_id0;
    logic [31:0] r_s0;
    logic [31:0] r_t0;

    // Entries 1..LAST: registered fadd results
    logic        r_v   [1:LAST];
    logic        r_id  [1:LAST];
    logic [31:0] r_d   [1:LAST];
    logic        r_ovf [1:LAST];

    // Requester granted most recently; reset to 1 so req0 wins first contention
    logic        r_last;

    logic        w_advance;
    logic        w_grant;
    logic        w_accept;
    logic        w_sub;
    logic [31:0] w_s;
    logic [31:0] w_t;
    logic        w_any_v;

    // The pipeline only moves when the output entry is empty or being consumed
    assign w_advance = ~r_v[LAST] | resp_ready;
    assign w_accept  = w_advance & (req0_valid | req1_valid);

    // Round-robin grant: a lone requester always wins, contention alternates
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end else begin
            w_grant = 1'b0;
        end
    end

    // Operand mux for the granted requester
    always_comb begin
        w_sub = 1'b0;
        w_s   = 32'h0000_0000;
        w_t   = 32'h0000_0000;
        if (w_grant) begin
            w_sub = req1_sub;
            w_s   = req1_s;
            w_t   = req1_t;
        end else begin
            w_sub = req0_sub;
            w_s   = req0_s;
            w_t   = req0_t;
        end
    end

    // Ready is only ever raised for the requester that actually wins the grant
    assign req0_ready = w_advance & req0_valid & (w_grant == 1'b0);
    assign req1_ready = w_advance & req1_valid & (w_grant == 1'b1);

    // OR of every entry valid bit
    always_comb begin
        w_any_v = r_v0;
        for (int k = 1; k <= LAST; k++) begin
            w_any_v = w_any_v | r_v[k];
        end
    end

    // Pipeline state: accept into entry 0, shift results toward the output
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v0   <= 1'b0;
            r_id0  <= 1'b0;
            r_s0   <= 32'h0000_0000;
            r_t0   <= 32'h0000_0000;
            r_last <= 1'b1;
            for (int k = 1; k <= LAST; k++) begin
                r_v[k]   <= 1'b0;
                r_id[k]  <= 1'b0;
                r_d[k]   <= 32'h0000_0000;
                r_ovf[k] <= 1'b0;
            end
        end else if (w_advance) begin
            if (w_accept) begin
                r_v0   <= 1'b1;
                r_id0  <= w_grant;
                r_s0   <= w_s;
                // Subtraction becomes addition with t negated (sign bit only)
                r_t0   <= w_t ^ {w_sub, 31'h0000_0000};
                r_last <= w_grant;
            end else begin
                r_v0   <= 1'b0;
            end
            r_v[1]   <= r_v0;
            r_id[1]  <= r_id0;
            r_d[1]   <= fadd_d;
            r_ovf[1] <= fadd_overflow;
            for (int k = 2; k <= LAST; k++) begin
                r_v[k]   <= r_v[k-1];
                r_id[k]  <= r_id[k-1];
                r_d[k]   <= r_d[k-1];
                r_ovf[k] <= r_ovf[k-1];
            end
        end
    end

    assign fadd_s        = r_s0;
    assign fadd_t        = r_t0;
    assign resp_valid    = r_v[LAST];
    assign resp_id       = r_id[LAST];
    assign resp_d        = r_d[LAST];
    assign resp_overflow = r_ovf[LAST];
    assign busy          = w_any_v;

endmodule

// File: tb/tb_fadd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fadd_arbiter
//   Directed bench for fadd_arbiter (LATENCY = 2). The shared fadd is replaced
//   by a small stand-in: a table of the exact IEEE sums used by the float
//   vectors, and a plain integer sum for the tagging/ordering vectors.
// -----------------------------------------------------------------------------
module tb_fadd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_sub;
    logic [31:0] req0_s, req0_t;
    logic        req1_valid, req1_ready, req1_sub;
    logic [31:0] req1_s, req1_t;
    logic [31:0] fadd_s, fadd_t, fadd_d;
    logic        fadd_overflow;
    logic        resp_valid, resp_ready, resp_id, resp_overflow, busy;
    logic [31:0] resp_d;

    int n_vec = 0;
    int n_err = 0;

    fadd_arbiter #(.LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sub(req0_sub),
        .req0_s(req0_s), .req0_t(req0_t),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sub(req1_sub),
        .req1_s(req1_s), .req1_t(req1_t),
        .fadd_s(fadd_s), .fadd_t(fadd_t), .fadd_d(fadd_d),
        .fadd_overflow(fadd_overflow),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_d(resp_d), .resp_overflow(resp_overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the shared combinational fadd
    always_comb begin
        fadd_overflow = 1'b0;
        case ({fadd_s, fadd_t})
            {32'h3F80_0000, 32'h4000_0000}: fadd_d = 32'h4040_0000;
            {32'h4040_0000, 32'hBF80_0000}: fadd_d = 32'h4000_0000;
            {32'h7F7F_FFFF, 32'h7F7F_FFFF}: begin
                fadd_d        = 32'h7F80_0000;
                fadd_overflow = 1'b1;
            end
            default: fadd_d = fadd_s + fadd_t;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic sub, input logic [31:0] s, input logic [31:0] t);
        req0_valid = v; req0_sub = sub; req0_s = s; req0_t = t;
    endtask

    task automatic set1(input logic v, input logic sub, input logic [31:0] s, input logic [31:0] t);
        req1_valid = v; req1_sub = sub; req1_s = s; req1_t = t;
    endtask

    initial begin
        rst = 1'b1;
        resp_ready = 1'b0;
        set0(1'b0, 1'b0, 32'h0, 32'h0);
        set1(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        // ---- reset state ----
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_d", resp_d, 32'h0);
        chk("rst_resp_id", {31'h0, resp_id}, 32'h0);
        chk("rst_resp_ovf", {31'h0, resp_overflow}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        rst = 1'b0;
        #1;
        chk("rst_req0_ready", {31'h0, req0_ready}, 32'h0);

        // ---- 1: req0 1.0 + 2.0 ----
        resp_ready = 1'b1;
        set0(1'b1, 1'b0, 32'h3F80_0000, 32'h4000_0000);
        #1;
        chk("t1_req0_ready", {31'h0, req0_ready}, 32'h1);
        chk("t1_req1_ready", {31'h0, req1_ready}, 32'h0);
        tick();
        set0(1'b0, 1'b0, 32'h0, 32'h0);
        chk("t1_fadd_s", fadd_s, 32'h3F80_0000);
        chk("t1_fadd_t", fadd_t, 32'h4000_0000);
        chk("t1_busy", {31'h0, busy}, 32'h1);
        chk("t1_early_valid", {31'h0, resp_valid}, 32'h0);
        tick();
        chk("t1_resp_valid", {31'h0, resp_valid}, 32'h1);
        chk("t1_resp_d", resp_d, 32'h4040_0000);
        chk("t1_resp_id", {31'h0, resp_id}, 32'h0);
        chk("t1_resp_ovf", {31'h0, resp_overflow}, 32'h0);
        tick();
        chk("t1_valid_off", {31'h0, resp_valid}, 32'h0);
        chk("t1_busy_off", {31'h0, busy}, 32'h0);

        // ---- 2: req1 3.0 - 1.0 ----
        set1(1'b1, 1'b1, 32'h4040_0000, 32'h3F80_0000);
        #1;
        chk("t2_req1_ready", {31'h0, req1_ready}, 32'h1);
        tick();
        set1(1'b0, 1'b0, 32'h0, 32'h0);
        chk("t2_fadd_s", fadd_s, 32'h4040_0000);
        chk("t2_fadd_t", fadd_t, 32'hBF80_0000);
        tick();
        chk("t2_resp_valid", {31'h0, resp_valid}, 32'h1);
        chk("t2_resp_d", resp_d, 32'h4000_0000);
        chk("t2_resp_id", {31'h0, resp_id}, 32'h1);

        // ---- 3: continuous contention, expect alternating grants ----
        for (int i = 0; i < 4; i++) begin
            set0(1'b1, 1'b0, 32'h0000_0001, 32'h0000_0002);
            set1(1'b1, 1'b0, 32'h0000_0010, 32'h0000_0020);
            #1;
            chk("t3_req0_ready", {31'h0, req0_ready}, (i % 2 == 0) ? 32'h1 : 32'h0);
            chk("t3_req1_ready", {31'h0, req1_ready}, (i % 2 == 0) ? 32'h0 : 32'h1);
            tick();
            if (i >= 1) begin
                chk("t3_resp_valid", {31'h0, resp_valid}, 32'h1);
                chk("t3_resp_id", {31'h0, resp_id}, ((i - 1) % 2 == 0) ? 32'h0 : 32'h1);
                chk("t3_resp_d", resp_d, ((i - 1) % 2 == 0) ? 32'h0000_0003 : 32'h0000_0030);
            end
        end
        set0(1'b0, 1'b0, 32'h0, 32'h0);
        set1(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("t3_last_valid", {31'h0, resp_valid}, 32'h1);
        chk("t3_last_id", {31'h0, resp_id}, 32'h1);
        chk("t3_last_d", resp_d, 32'h0000_0030);
        tick();
        chk("t3_drained", {31'h0, resp_valid}, 32'h0);

        // ---- 4: backpressure with three operations ----
        resp_ready = 1'b0;
        set0(1'b1, 1'b0, 32'h0000_0100, 32'h0000_0001);
        tick();
        set0(1'b1, 1'b0, 32'h0000_0200, 32'h0000_0002);
        tick();
        set0(1'b1, 1'b0, 32'h0000_0300, 32'h0000_0003);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t4_stall_ready", {31'h0, req0_ready}, 32'h0);
            chk("t4_stall_valid", {31'h0, resp_valid}, 32'h1);
            chk("t4_stall_d", resp_d, 32'h0000_0101);
            chk("t4_stall_id", {31'h0, resp_id}, 32'h0);
            chk("t4_stall_busy", {31'h0, busy}, 32'h1);
            tick();
        end
        resp_ready = 1'b1;
        #1;
        chk("t4_release_ready", {31'h0, req0_ready}, 32'h1);
        tick();
        set0(1'b0, 1'b0, 32'h0, 32'h0);
        chk("t4_second_valid", {31'h0, resp_valid}, 32'h1);
        chk("t4_second_d", resp_d, 32'h0000_0202);
        tick();
        chk("t4_third_valid", {31'h0, resp_valid}, 32'h1);
        chk("t4_third_d", resp_d, 32'h0000_0303);
        tick();
        chk("t4_empty_valid", {31'h0, resp_valid}, 32'h0);
        chk("t4_empty_busy", {31'h0, busy}, 32'h0);

        // ---- 5: overflow passes through ----
        set0(1'b1, 1'b0, 32'h7F7F_FFFF, 32'h7F7F_FFFF);
        tick();
        set0(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("t5_resp_d", resp_d, 32'h7F80_0000);
        chk("t5_resp_ovf", {31'h0, resp_overflow}, 32'h1);
        tick();

        // ---- 6: reset with two operations in flight ----
        set0(1'b1, 1'b0, 32'h0000_0005, 32'h0000_0006);
        tick();
        set0(1'b1, 1'b0, 32'h0000_0007, 32'h0000_0008);
        tick();
        chk("t6_pre_valid", {31'h0, resp_valid}, 32'h1);
        rst = 1'b1;
        set0(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        rst = 1'b0;
        chk("t6_rst_valid", {31'h0, resp_valid}, 32'h0);
        chk("t6_rst_busy", {31'h0, busy}, 32'h0);
        set0(1'b1, 1'b0, 32'h0000_0040, 32'h0000_0002);
        set1(1'b1, 1'b0, 32'h0000_0080, 32'h0000_0004);
        #1;
        chk("t6_req0_ready", {31'h0, req0_ready}, 32'h1);
        chk("t6_req1_ready", {31'h0, req1_ready}, 32'h0);
        tick();
        set0(1'b0, 1'b0, 32'h0, 32'h0);
        set1(1'b0, 1'b0, 32'h0, 32'h0);
        chk("t6_fadd_s", fadd_s, 32'h0000_0040);
        tick();
        chk("t6_resp_id", {31'h0, resp_id}, 32'h0);
        chk("t6_resp_d", resp_d, 32'h0000_0042);
        tick();
        chk("t6_no_extra", {31'h0, resp_valid}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
